// File: rtl/memory_access_controller.sv
// -----------------------------------------------------------------------------
// memory_access_controller
//
// Sequences single load/store operations from the MEM stage onto a word-wide
// data memory using a req/ready handshake. Stores get big-endian byte enables
// and lane-replicated write data. Loads extract the addressed byte/half lane
// and sign- or zero-extend it. The pipeline is held via stall until the
// access completes. Misaligned, reserved-size and timed-out accesses complete
// with rsp_error set.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   op_*                MEM-stage request (valid/write/addr/size/sign/wdata)
//   op_ready            controller idle and able to accept
//   stall               hold MEM stage and earlier
//   rsp_valid/rdata/error  one-cycle completion pulse with load data / error
//   mem_req/we/addr/be/wdata  registered memory request, held until mem_ready
//   mem_ready/rdata     memory completion and read word
// -----------------------------------------------------------------------------
module memory_access_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255  // 0 disables the timeout
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic                  op_write,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [1:0]            op_size,
  input  logic                  op_sign_extend,
  input  logic [31:0]           op_wdata,
  output logic                  op_ready,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_BYTE = 2'd2,
    SIZE_RSVD = 2'd3
  } op_size_t;

  // Counter holds 0 .. TIMEOUT_CYCLES-1; the last value marks the final
  // cycle mem_req may be answered before the access is abandoned.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  op_size_t         size_q;
  logic [1:0]       lane_q;
  logic             sext_q;

  // Decode of the incoming op, used only on the accept cycle.
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the case statement leaves it unassigned (no latch).
  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = op_wdata;
    case (op_size_t'(op_size))
      SIZE_WORD: misaligned = (op_addr[1:0] != 2'b00);
      SIZE_HALF: begin
        misaligned = op_addr[0];
        wdata_next = {2{op_wdata[15:0]}};
        if (op_write) be_next = op_addr[1] ? 4'b0011 : 4'b1100;
      end
      SIZE_BYTE: begin
        wdata_next = {4{op_wdata[7:0]}};
        if (op_write) be_next = 4'b1000 >> op_addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Big-endian lane extraction and extension of the returned load word.
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    lane_byte = mem_rdata[31:24];
    case (lane_q)
      2'd0: lane_byte = mem_rdata[31:24];
      2'd1: lane_byte = mem_rdata[23:16];
      2'd2: lane_byte = mem_rdata[15:8];
      2'd3: lane_byte = mem_rdata[7:0];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = lane_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      SIZE_HALF: load_data = {{16{sext_q & lane_half[15]}}, lane_half};
      SIZE_BYTE: load_data = {{24{sext_q & lane_byte[7]}}, lane_byte};
      default:   load_data = mem_rdata;
    endcase
  end

  assign op_ready = (state == IDLE) && !reset;
  assign stall    = ((state == IDLE) && op_valid) || (state == ACCESS);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      size_q    <= SIZE_WORD;
      lane_q    <= 2'b00;
      sext_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= '0;
          wait_cnt  <= '0;
          if (op_valid) begin
            size_q <= op_size_t'(op_size);
            lane_q <= op_addr[1:0];
            sext_q <= op_sign_extend;
            if (misaligned) begin
              // Bad op never reaches memory; respond with error next cycle.
              state     <= RESPOND;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= op_write;
              mem_addr  <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end

        ACCESS: begin
          // mem_ready is checked first so a reply on the limit cycle wins.
          if (mem_ready || (TIMEOUT_EN && (wait_cnt == CNT_LAST))) begin
            state     <= RESPOND;
            rsp_valid <= 1'b1;
            rsp_error <= !mem_ready;
            rsp_rdata <= (mem_ready && !mem_we) ? load_data : 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESPOND: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= '0;
          wait_cnt  <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// -----------------------------------------------------------------------------
// tb_memory_access_controller
//
// Cycle-level bench for memory_access_controller. Each operation is driven
// through a task that predicts the memory request and the response from a
// transaction-level model (plain arithmetic on address/size), then checks the
// DUT every cycle. Directed cases cover the documented examples and limits;
// a randomized loop follows. Inputs are driven 1 time unit after the rising
// edge and outputs sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_memory_access_controller;

  localparam int AW = 32;
  localparam int T  = 4;  // timeout limit used for this instance

  logic          clock;
  logic          reset;
  logic          op_valid;
  logic          op_write;
  logic [AW-1:0] op_addr;
  logic [1:0]    op_size;
  logic          op_sign_extend;
  logic [31:0]   op_wdata;
  logic          op_ready;
  logic          stall;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] last_rdata;
  logic        last_error;

  memory_access_controller #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_write      (op_write),
    .op_addr       (op_addr),
    .op_size       (op_size),
    .op_sign_extend(op_sign_extend),
    .op_wdata      (op_wdata),
    .op_ready      (op_ready),
    .stall         (stall),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Garbage on the op bus while the controller is busy must be ignored.
  task automatic scramble_op();
    op_valid       = 1'($urandom_range(0, 1));
    op_write       = 1'($urandom_range(0, 1));
    op_addr        = $urandom;
    op_size        = 2'($urandom_range(0, 3));
    op_sign_extend = 1'($urandom_range(0, 1));
    op_wdata       = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      op_valid  = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      check("idle_op_ready", op_ready, 1);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_mem_req", mem_req, 0);
      check("idle_stall", stall, 0);
    end
  endtask

  // lat = cycles mem_ready stays low in ACCESS before it rises; lat >= T
  // means it never rises and the access must time out.
  task automatic run_op(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input bit sx, input logic [31:0] wd, input logic [31:0] rd,
                        input int lat);
    bit          mis;
    bit          tmo;
    int          b;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [31:0] v;

    b      = int'(addr[1:0]);
    mis    = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd0 && b != 0);
    tmo    = (lat >= T);
    e_addr = addr & ~32'd3;
    e_be   = 4'hF;
    e_wdata = wd;
    e_rdata = rd;
    if (size == 2'd2) begin
      e_wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      if (wr) e_be = 4'(1 << (3 - b));
      v = (rd >> (8 * (3 - b))) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      e_rdata = v;
    end else if (size == 2'd1) begin
      e_wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      if (wr) e_be = (b >= 2) ? 4'b0011 : 4'b1100;
      v = (rd >> ((b >= 2) ? 0 : 16)) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      e_rdata = v;
    end

    // Cycle 0: present the op in IDLE.
    next_cycle();
    check("accept_op_ready", op_ready, 1);
    op_valid       = 1'b1;
    op_write       = wr;
    op_addr        = addr;
    op_size        = size;
    op_sign_extend = sx;
    op_wdata       = wd;
    mem_ready      = 1'($urandom_range(0, 1));
    mem_rdata      = $urandom;
    #1;
    check("accept_stall", stall, 1);
    check("accept_rsp_valid", rsp_valid, 0);

    if (!mis) begin
      for (int i = 1; i <= T; i++) begin
        next_cycle();
        scramble_op();
        mem_ready = (i - 1 == lat);
        mem_rdata = (i - 1 == lat) ? rd : $urandom;
        #1;
        check("acc_mem_req", mem_req, 1);
        check("acc_mem_we", mem_we, wr);
        check("acc_mem_addr", mem_addr, e_addr);
        check("acc_mem_be", mem_be, e_be);
        check("acc_mem_wdata", mem_wdata, e_wdata);
        check("acc_stall", stall, 1);
        check("acc_rsp_valid", rsp_valid, 0);
        check("acc_op_ready", op_ready, 0);
        if (i - 1 == lat) break;
      end
    end

    // Response cycle.
    next_cycle();
    scramble_op();
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_error", rsp_error, mis || tmo);
    check("rsp_rdata", rsp_rdata, (mis || tmo || wr) ? 32'd0 : e_rdata);
    check("rsp_mem_req", mem_req, 0);
    check("rsp_stall", stall, 0);
    check("rsp_op_ready", op_ready, 0);
    last_rdata = rsp_rdata;
    last_error = rsp_error;
  endtask

  task automatic reset_mid_access();
    next_cycle();
    op_valid = 1'b1; op_write = 1'b0; op_addr = 32'h100; op_size = 2'd0;
    op_sign_extend = 1'b0; op_wdata = '0; mem_ready = 1'b0;
    #1;
    check("rst_accept_stall", stall, 1);
    next_cycle();
    op_valid = 1'b0;
    #1;
    check("rst_acc_mem_req", mem_req, 1);
    next_cycle();
    reset = 1'b1;
    #1;
    check("rst_op_ready_low", op_ready, 0);
    next_cycle();
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rst_mem_req_dropped", mem_req, 0);
    check("rst_no_rsp0", rsp_valid, 0);
    check("rst_op_ready_back", op_ready, 1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mem_ready = 1'b0;
      #1;
      check("rst_no_rsp", rsp_valid, 0);
      check("rst_mem_req_low", mem_req, 0);
      check("rst_op_ready", op_ready, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op_write = 1'b0; op_addr = '0; op_size = '0;
    op_sign_extend = 1'b0; op_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    last_rdata = '0; last_error = 1'b0;

    next_cycle();
    next_cycle();
    check("reset_op_ready", op_ready, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_mem_be", mem_be, 0);
    check("reset_stall", stall, 0);
    reset = 1'b0;
    idle_cycles(1);

    // Documented examples.
    run_op(1'b0, 32'h1003, 2'd2, 1'b1, 32'h0, 32'h1234_56F0, 1);
    check("ex1_rdata", last_rdata, 32'hFFFF_FFF0);
    run_op(1'b0, 32'h2002, 2'd1, 1'b0, 32'h0, 32'hAAAA_8001, 0);
    check("ex2_rdata", last_rdata, 32'h0000_8001);
    run_op(1'b1, 32'h0011, 2'd2, 1'b0, 32'h0000_005A, 32'h0, 2);
    run_op(1'b0, 32'h0006, 2'd0, 1'b0, 32'h0, 32'h0, 0);
    check("ex4_error", last_error, 1);
    run_op(1'b0, 32'h0040, 2'd0, 1'b0, 32'h0, 32'h0, 10);
    check("ex5_error", last_error, 1);
    reset_mid_access();

    // Limits: reply on the timeout cycle wins, half lanes, reserved size.
    run_op(1'b0, 32'h0080, 2'd0, 1'b1, 32'h0, 32'h8765_4321, T - 1);
    check("limit_no_error", last_error, 0);
    run_op(1'b1, 32'h0102, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0, 0);
    run_op(1'b1, 32'h0100, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0, 1);
    run_op(1'b0, 32'h0200, 2'd1, 1'b1, 32'h0, 32'h9ABC_0123, 0);
    run_op(1'b1, 32'h0301, 2'd1, 1'b0, 32'h0, 32'h0, 0);
    run_op(1'b0, 32'h0400, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    run_op(1'b1, 32'h0500, 2'd0, 1'b0, 32'hCAFE_F00D, 32'h0, 3);
    idle_cycles(2);

    // Randomized ops, mostly aligned, with occasional idle gaps.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0]   = 1'b0;
      end
      run_op(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom_range(0, T + 1));
      if ($urandom_range(0, 4) == 0) idle_cycles(1);
    end
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
